// File: rtl/mux_sched_pkg.sv
// Shared types and sizing for the mux select sequencer.
package mux_sched_pkg;

  localparam int unsigned CH_NUM = 4;
  localparam int unsigned SEL_W  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    DWELL = 1'b1
  } state_e;

endpackage

// File: rtl/rr_next_ch.sv
// Round-robin helper: next enabled channel after cur (with wrap) and
// whether cur is the highest enabled channel.
module rr_next_ch
  import mux_sched_pkg::*;
(
  input  logic [CH_NUM-1:0] mask_i,
  input  logic [SEL_W-1:0]  cur_i,
  output logic [SEL_W-1:0]  next_o,
  output logic              is_last_o
);

  logic             found;
  logic             higher;
  logic [SEL_W-1:0] idx;

  // Scan upward from cur+1; with an empty mask the current index is returned.
  always_comb begin
    next_o = cur_i;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 1; k <= CH_NUM; k++) begin
      idx = SEL_W'((32'(cur_i) + k) % CH_NUM);
      if (!found && mask_i[idx]) begin
        next_o = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    higher = 1'b0;
    for (int unsigned k = 0; k < CH_NUM; k++) begin
      if (k > 32'(cur_i) && mask_i[SEL_W'(k)]) begin
        higher = 1'b1;
      end
    end
    is_last_o = mask_i[cur_i] && !higher;
  end

endmodule

// File: rtl/mux_sel_sequencer.sv
// Round-robin select sequencer for a downstream 4:1 selector, with per-channel
// dwell, sample strobe on the last dwell cycle and sweep-complete strobe.
module mux_sel_sequencer
  import mux_sched_pkg::*;
#(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic [3:0]         i_ch_en,
  input  logic [DWELL_W-1:0] i_dwell,
  output logic [1:0]         o_sel,
  output logic               o_sample,
  output logic               o_frame_done,
  output logic               o_busy
);

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [DWELL_W-1:0]  cnt_q, cnt_d;
  logic [DWELL_W-1:0]  reload_q, reload_d;
  logic [CH_NUM-1:0]   mask_q, mask_d;
  logic                stop_pend_q, stop_pend_d;

  logic [CH_NUM-1:0]   rr_mask;
  logic [SEL_W-1:0]    rr_cur;
  logic [SEL_W-1:0]    rr_next;
  logic                rr_is_last;
  logic [DWELL_W-1:0]  start_reload;

  // One scanner serves both jobs: in IDLE it finds the lowest enabled channel
  // of the incoming mask (cur = top channel, so the scan wraps to bit 0); in
  // DWELL it works on the latched mask and current select only.
  always_comb begin
    if (state_q == DWELL) begin
      rr_mask = mask_q;
      rr_cur  = sel_q;
    end else begin
      rr_mask = i_ch_en;
      rr_cur  = SEL_W'(CH_NUM - 1);
    end
  end

  rr_next_ch u_rr_next_ch (
    .mask_i    (rr_mask),
    .cur_i     (rr_cur),
    .next_o    (rr_next),
    .is_last_o (rr_is_last)
  );

  assign start_reload = (i_dwell == '0) ? '0 : i_dwell - DWELL_W'(1);

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    reload_d    = reload_q;
    mask_d      = mask_q;
    stop_pend_d = stop_pend_q;
    case (state_q)
      IDLE: begin
        if (i_start && !i_stop && (i_ch_en != '0)) begin
          mask_d      = i_ch_en;
          reload_d    = start_reload;
          cnt_d       = start_reload;
          sel_d       = rr_next;
          stop_pend_d = 1'b0;
          state_d     = DWELL;
        end
      end
      DWELL: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
          if (i_stop) begin
            stop_pend_d = 1'b1;
          end
        end else if (stop_pend_q || i_stop) begin
          state_d     = IDLE;
          sel_d       = '0;
          stop_pend_d = 1'b0;
        end else begin
          sel_d = rr_next;
          cnt_d = reload_q;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      cnt_q       <= '0;
      reload_q    <= '0;
      mask_q      <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      reload_q    <= reload_d;
      mask_q      <= mask_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  assign o_busy       = (state_q == DWELL);
  assign o_sel        = sel_q;
  assign o_sample     = o_busy && (cnt_q == '0);
  assign o_frame_done = o_sample && rr_is_last;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Directed scoreboard bench for mux_sel_sequencer.
module tb_mux_sel_sequencer;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_start;
  logic       i_stop;
  logic [3:0] i_ch_en;
  logic [7:0] i_dwell;
  logic [1:0] o_sel;
  logic       o_sample;
  logic       o_frame_done;
  logic       o_busy;

  typedef struct {
    logic       busy;
    logic [1:0] sel;
    logic       sample;
    logic       fd;
  } exp_t;

  exp_t        sbq[$];
  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc    = 0;

  mux_sel_sequencer #(.DWELL_W(8)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_stop       (i_stop),
    .i_ch_en      (i_ch_en),
    .i_dwell      (i_dwell),
    .o_sel        (o_sel),
    .o_sample     (o_sample),
    .o_frame_done (o_frame_done),
    .o_busy       (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s @cyc%0d: observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic push_exp(input logic b, input logic [1:0] s, input logic sm, input logic fd);
    exp_t e;
    e.busy = b; e.sel = s; e.sample = sm; e.fd = fd;
    sbq.push_back(e);
  endtask

  task automatic push_idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) push_exp(1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  // Expected sweep: enabled channels in ascending order, each held d cycles.
  task automatic push_sweep(input logic [3:0] m, input int unsigned d, input int unsigned n);
    logic [1:0]  chl[$];
    logic [1:0]  ch;
    int unsigned idx;
    logic        sm;
    for (int i = 0; i < 4; i++) begin
      ch = 2'(i);
      if (m[i]) chl.push_back(ch);
    end
    for (int unsigned c = 0; c < n; c++) begin
      idx = (c / d) % chl.size();
      sm  = ((c % d) == (d - 1));
      push_exp(1'b1, chl[idx], sm, sm && (idx == chl.size() - 1));
    end
  endtask

  // Compare one scoreboard entry per cycle at the falling edge, then drop pulses.
  task automatic run_cycles(input int unsigned n);
    exp_t e;
    repeat (n) begin
      @(negedge i_clk);
      cyc++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL scoreboard @cyc%0d: observed=empty expected=entry", cyc);
      end else begin
        e = sbq.pop_front();
        chk("busy",   8'(o_busy),       8'(e.busy));
        chk("sel",    8'(o_sel),        8'(e.sel));
        chk("sample", 8'(o_sample),     8'(e.sample));
        chk("frame",  8'(o_frame_done), 8'(e.fd));
      end
      i_start = 1'b0;
      i_stop  = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_stop  = 1'b0;
    i_ch_en = 4'b0000;
    i_dwell = 8'd0;
    #1;
    chk("rst_busy",   8'(o_busy),       8'd0);
    chk("rst_sel",    8'(o_sel),        8'd0);
    chk("rst_sample", 8'(o_sample),     8'd0);
    chk("rst_frame",  8'(o_frame_done), 8'd0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Full sweep D=2, with start/mask/dwell churn while busy, stop on a sample cycle.
    push_sweep(4'b1111, 2, 16);
    push_idle(2);
    i_ch_en = 4'b1111; i_dwell = 8'd2; i_start = 1'b1;
    run_cycles(5);
    i_start = 1'b1; i_ch_en = 4'b0001; i_dwell = 8'd7;
    run_cycles(11);
    i_stop = 1'b1;
    run_cycles(2);

    // Sparse mask, D=1.
    push_sweep(4'b1010, 1, 8);
    push_idle(2);
    i_ch_en = 4'b1010; i_dwell = 8'd1; i_start = 1'b1;
    run_cycles(8);
    i_stop = 1'b1;
    run_cycles(2);

    // Dwell of zero acts as one; single channel fires sample and frame every cycle.
    push_sweep(4'b0100, 1, 4);
    push_idle(1);
    i_ch_en = 4'b0100; i_dwell = 8'd0; i_start = 1'b1;
    run_cycles(4);
    i_stop = 1'b1;
    run_cycles(1);

    // Empty mask: start ignored.
    push_idle(3);
    i_ch_en = 4'b0000; i_dwell = 8'd3; i_start = 1'b1;
    run_cycles(3);

    // Start and stop together: stop wins.
    push_idle(3);
    i_ch_en = 4'b1111; i_dwell = 8'd2; i_start = 1'b1; i_stop = 1'b1;
    run_cycles(3);

    // Stop mid-dwell on channel 1 (D=4): channel 1 still completes with its sample.
    push_sweep(4'b1111, 4, 8);
    push_idle(2);
    i_ch_en = 4'b1111; i_dwell = 8'd4; i_start = 1'b1;
    run_cycles(6);
    i_stop = 1'b1;
    run_cycles(4);

    // Asynchronous reset mid-sweep.
    push_sweep(4'b1111, 3, 5);
    i_ch_en = 4'b1111; i_dwell = 8'd3; i_start = 1'b1;
    run_cycles(5);
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_busy",   8'(o_busy),       8'd0);
    chk("arst_sel",    8'(o_sel),        8'd0);
    chk("arst_sample", 8'(o_sample),     8'd0);
    chk("arst_frame",  8'(o_frame_done), 8'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    push_idle(2);
    run_cycles(2);

    // Restart after reset with only the top channel enabled.
    push_sweep(4'b1000, 2, 4);
    i_ch_en = 4'b1000; i_dwell = 8'd2; i_start = 1'b1;
    run_cycles(4);

    chk("sb_drained", 8'(sbq.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
